// File: rtl/requant_pack_stage_pkg.sv
// requant_pack_stage_pkg: shared constants and arithmetic helpers for the requantise/pack stage.
//   C_OUT_LANES        int8 results per packed output beat
//   INT8_MIN/INT8_MAX  saturation bounds of the int8 result
//   round_shift        rounding (half up) arithmetic right shift; shift 0 passes through
//   relu_floor         lower clamp bound, raised to the zero point when ReLU is enabled
//   clamp8             saturates a wide signed value into [lo, INT8_MAX]
package requant_pack_stage_pkg;
   localparam int C_OUT_LANES = 4;
   localparam logic signed [7:0] INT8_MIN = 8'sh80;
   localparam logic signed [7:0] INT8_MAX = 8'sh7F;

   function automatic logic signed [63:0] round_shift(input logic signed [63:0] p, input logic [5:0] sh);
      return sh == 6'd0 ? p : (p + (64'sd1 <<< (sh - 6'd1))) >>> sh;
   endfunction

   function automatic logic signed [7:0] relu_floor(input logic signed [7:0] zp, input logic relu);
      return relu && zp > INT8_MIN ? zp : INT8_MIN;
   endfunction

   function automatic logic [7:0] clamp8(input logic signed [63:0] q, input logic signed [7:0] lo);
      return q < 64'(lo) ? lo : q > 64'(INT8_MAX) ? INT8_MAX : q[7:0];
   endfunction
endpackage

// File: rtl/requant_lane.sv
// requant_lane: three-stage bias / scale / round-shift-clamp pipeline with a common stall enable.
//   clk, rst          clock and synchronous active-high reset
//   en                advance enable; every register holds while low
//   in_*              element entering S1 (valid, accumulator, last, tag)
//   bias..relu        quasi-static requantisation parameters
//   out_*             S3 result: valid, int8 value, last, tag
//   busy              any stage holds a valid element
module requant_lane
   import requant_pack_stage_pkg::*;
#(
   parameter int C_ACC_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          in_valid,
   input  logic signed [C_ACC_WIDTH-1:0] acc,
   input  logic                          in_last,
   input  logic [7:0]                    in_id,
   input  logic signed [31:0]            bias,
   input  logic [15:0]                   scale,
   input  logic [5:0]                    shift,
   input  logic signed [7:0]             zp,
   input  logic                          relu,
   output logic                          out_valid,
   output logic [7:0]                    out_data,
   output logic                          out_last,
   output logic [7:0]                    out_id,
   output logic                          busy
);
   localparam int BW = C_ACC_WIDTH + 1;
   localparam int PW = BW + 17;

   logic                 v1, v2, l1, l2;
   logic [7:0]           id1, id2;
   logic signed [BW-1:0] b;
   logic signed [PW-1:0] p;
   logic signed [63:0]   q;

   always_comb q = round_shift(64'(p), shift) + 64'(zp);

   assign busy = v1 | v2 | out_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         l1        <= 1'b0;
         l2        <= 1'b0;
         out_last  <= 1'b0;
         id1       <= '0;
         id2       <= '0;
         out_id    <= '0;
         b         <= '0;
         p         <= '0;
         out_data  <= '0;
      end else if (en) begin
         v1        <= in_valid;
         b         <= BW'(acc) + BW'(bias);
         l1        <= in_last;
         id1       <= in_id;
         v2        <= v1;
         // scale is unsigned: a zero sign bit keeps the signed product correct
         p         <= PW'(b) * PW'($signed({1'b0, scale}));
         l2        <= l1;
         id2       <= id1;
         out_valid <= v2;
         out_data  <= clamp8(q, relu_floor(zp, relu));
         out_last  <= l2;
         out_id    <= id2;
      end
   end
endmodule

// File: rtl/requant_pack_stage.sv
// requant_pack_stage: requantises a 32-bit accumulator stream to int8 and packs lanes into output beats.
//   ACLK, ARESET        clock and synchronous active-high reset
//   SD_AXIS_*           accumulator input stream (TVALID/TREADY/TDATA/TLAST/TID)
//   MO_AXIS_*           packed int8 output stream (TVALID/TREADY/TDATA/TKEEP/TLAST/TID)
//   CFG_*               bias, scale, shift, zero point and ReLU enable (change only while IDLE)
//   IDLE                pipeline, pack buffer and output register all empty
module requant_pack_stage #(
   parameter int C_ACC_WIDTH = 32,
   parameter int C_OUT_LANES = requant_pack_stage_pkg::C_OUT_LANES
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic                          SD_AXIS_TVALID,
   output logic                          SD_AXIS_TREADY,
   input  logic signed [C_ACC_WIDTH-1:0] SD_AXIS_TDATA,
   input  logic                          SD_AXIS_TLAST,
   input  logic [7:0]                    SD_AXIS_TID,
   output logic                          MO_AXIS_TVALID,
   input  logic                          MO_AXIS_TREADY,
   output logic [8*C_OUT_LANES-1:0]      MO_AXIS_TDATA,
   output logic [C_OUT_LANES-1:0]        MO_AXIS_TKEEP,
   output logic                          MO_AXIS_TLAST,
   output logic [7:0]                    MO_AXIS_TID,
   input  logic signed [31:0]            CFG_BIAS,
   input  logic [15:0]                   CFG_SCALE,
   input  logic [5:0]                    CFG_SHIFT,
   input  logic signed [7:0]             CFG_ZP,
   input  logic                          CFG_RELU,
   output logic                          IDLE
);
   import requant_pack_stage_pkg::*;

   localparam int CW = $clog2(C_OUT_LANES) + 1;

   logic                            adv, v3, l3, busy, flush, in_pkt;
   logic [7:0]                      y3, id3, pid;
   logic [CW-1:0]                   cnt, n;
   logic [C_OUT_LANES-1:0][7:0]     lanes, beat;
   logic [C_OUT_LANES-1:0]          keep;

   // The whole block stalls only while a beat sits unaccepted in the output register
   assign adv            = !MO_AXIS_TVALID || MO_AXIS_TREADY;
   assign SD_AXIS_TREADY = adv;
   assign IDLE           = !busy && cnt == '0 && !MO_AXIS_TVALID;

   requant_lane #(.C_ACC_WIDTH(C_ACC_WIDTH)) u_lane (
      .clk      (ACLK),
      .rst      (ARESET),
      .en       (adv),
      .in_valid (SD_AXIS_TVALID),
      .acc      (SD_AXIS_TDATA),
      .in_last  (SD_AXIS_TLAST),
      .in_id    (SD_AXIS_TID),
      .bias     (CFG_BIAS),
      .scale    (CFG_SCALE),
      .shift    (CFG_SHIFT),
      .zp       (CFG_ZP),
      .relu     (CFG_RELU),
      .out_valid(v3),
      .out_data (y3),
      .out_last (l3),
      .out_id   (id3),
      .busy     (busy)
   );

   // The closing element is merged straight into the outgoing beat rather than the buffer
   always_comb begin
      n     = cnt + CW'(1);
      flush = v3 && (n == CW'(C_OUT_LANES) || l3);
      beat  = '0;
      keep  = '0;
      for (int i = 0; i < C_OUT_LANES; i++) begin
         beat[i] = i < int'(cnt) ? lanes[i] : i == int'(cnt) ? y3 : 8'd0;
         keep[i] = i < int'(n);
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         cnt            <= '0;
         lanes          <= '0;
         in_pkt         <= 1'b0;
         pid            <= '0;
         MO_AXIS_TVALID <= 1'b0;
         MO_AXIS_TDATA  <= '0;
         MO_AXIS_TKEEP  <= '0;
         MO_AXIS_TLAST  <= 1'b0;
         MO_AXIS_TID    <= '0;
      end else if (adv) begin
         MO_AXIS_TVALID <= flush;
         if (v3) in_pkt <= !l3;
         // Tag comes from the first element of the packet, even across beat boundaries
         if (v3 && !in_pkt) pid <= id3;
         if (flush) begin
            MO_AXIS_TDATA <= beat;
            MO_AXIS_TKEEP <= keep;
            MO_AXIS_TLAST <= l3;
            MO_AXIS_TID   <= in_pkt ? pid : id3;
            cnt           <= '0;
         end else if (v3) begin
            lanes[cnt[CW-2:0]] <= y3;
            cnt                <= n;
         end
      end
   end
endmodule
